// File: rtl/bp_pkg.sv
// Shared branch predictor types: BTB entry kinds, per-entry state bits and counter helpers.
// Tag and target widths depend on module parameters, so they are stored beside bp_entry_t.
package bp_pkg;

  typedef enum logic [1:0] {
    BP_BR  = 2'd0,
    BP_JMP = 2'd1,
    BP_RET = 2'd2
  } bp_kind_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] ctr;
    bp_kind_e   kind;
  } bp_entry_t;

  localparam logic [1:0] CTR_WEAK_T   = 2'b10;
  localparam logic [1:0] CTR_STRONG_T = 2'b11;

  // Saturating 2-bit counter step: 3 stays 3 when taken, 0 stays 0 when not taken.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != 2'b11) nxt = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Return-address stack: circular storage with a saturating occupancy count.
// Only compiled when BP_RAS_EN is defined; a push when full overwrites the oldest entry.
`ifdef BP_RAS_EN
module bp_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             valid_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d, pop_ptr;
  logic [PW:0]      count_q, count_d, pop_count;

  // Pop is applied first, so a simultaneous pop+push replaces the top entry.
  always_comb begin
    pop_ptr   = ptr_q;
    pop_count = count_q;
    if (pop_i && (count_q != '0)) begin
      pop_ptr   = ptr_q - PW'(1);
      pop_count = count_q - (PW+1)'(1);
    end
    ptr_d   = pop_ptr;
    count_d = pop_count;
    if (push_i) begin
      ptr_d = pop_ptr + PW'(1);
      if (pop_count != FULL) count_d = pop_count + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      if (push_i) stack_q[pop_ptr] <= push_data_i;
    end
  end

  assign top_o   = stack_q[ptr_q - PW'(1)];
  assign valid_o = (count_q != '0);

endmodule
`endif

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit saturating counters.
// Define BP_RAS_EN to add a return-address stack that supplies targets for RET entries.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ENTRIES   = 64,
  parameter int TAG_BITS  = 8,
  parameter int RAS_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_f,
  output logic             pred_taken_f,
  output logic [WIDTH-1:0] pred_target_f,
  input  logic             update_valid_e,
  input  logic [WIDTH-1:0] pc_e,
  input  logic [WIDTH-1:0] pc_plus4_e,
  input  logic             branch_e,
  input  logic             jump_e,
  input  logic             jalr_e,
  input  logic             taken_e,
  input  logic [WIDTH-1:0] target_e,
  input  logic             is_call_e,
  input  logic             is_ret_e,
  input  logic             pred_taken_e,
  input  logic [WIDTH-1:0] pred_target_e,
  output logic             mispredict_e,
  output logic [WIDTH-1:0] redirect_pc_e
);
  localparam int IDX = $clog2(ENTRIES);

  bp_entry_t           meta_q   [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [WIDTH-1:0]    target_q [ENTRIES];

  logic [IDX-1:0]      idx_f, idx_e;
  logic [TAG_BITS-1:0] tag_f, tag_e;
  bp_entry_t           meta_f, meta_e;
  logic                hit_f, hit_e;
  bp_entry_t           wr_meta_d;
  logic                wr_en_d, wr_target_en_d;
  logic                unused_bits;

  assign idx_f  = pc_f[IDX+1:2];
  assign tag_f  = pc_f[TAG_BITS+IDX+1:IDX+2];
  assign idx_e  = pc_e[IDX+1:2];
  assign tag_e  = pc_e[TAG_BITS+IDX+1:IDX+2];
  assign meta_f = meta_q[idx_f];
  assign meta_e = meta_q[idx_e];
  assign hit_f  = meta_f.valid && (tag_q[idx_f] == tag_f);
  assign hit_e  = meta_e.valid && (tag_q[idx_e] == tag_e);

`ifdef BP_RAS_EN
  logic             ras_valid;
  logic [WIDTH-1:0] ras_top;

  bp_ras #(
    .WIDTH(WIDTH),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst        (rst),
    .push_i     (update_valid_e && is_call_e),
    .pop_i      (update_valid_e && is_ret_e),
    .push_data_i(pc_plus4_e),
    .top_o      (ras_top),
    .valid_o    (ras_valid)
  );
`else
  localparam int unused_ras_depth = RAS_DEPTH;
`endif

  assign unused_bits = ^{pc_f, pc_e, jalr_e, is_call_e, is_ret_e};

  // Fetch lookup sees the table as it was before this cycle's update.
  always_comb begin
    pred_taken_f  = 1'b0;
    pred_target_f = '0;
    if (hit_f) begin
      pred_taken_f  = (meta_f.kind != BP_BR) || meta_f.ctr[1];
      pred_target_f = target_q[idx_f];
`ifdef BP_RAS_EN
      if ((meta_f.kind == BP_RET) && ras_valid) pred_target_f = ras_top;
`endif
    end
  end

  assign mispredict_e  = update_valid_e &&
                         ((pred_taken_e != taken_e) || (taken_e && (pred_target_e != target_e)));
  assign redirect_pc_e = !update_valid_e ? '0 : (taken_e ? target_e : pc_plus4_e);

  // A hit on a non-control instruction is an alias and gets evicted.
  always_comb begin
    wr_en_d        = 1'b0;
    wr_target_en_d = 1'b0;
    wr_meta_d      = meta_e;
    if (update_valid_e) begin
      if (branch_e) begin
        if (hit_e) begin
          wr_en_d        = 1'b1;
          wr_target_en_d = taken_e;
          wr_meta_d.ctr  = ctr_next(meta_e.ctr, taken_e);
        end else if (taken_e) begin
          wr_en_d        = 1'b1;
          wr_target_en_d = 1'b1;
          wr_meta_d      = '{valid: 1'b1, ctr: CTR_WEAK_T, kind: BP_BR};
        end
      end else if (jump_e) begin
        wr_en_d        = 1'b1;
        wr_target_en_d = 1'b1;
`ifdef BP_RAS_EN
        wr_meta_d      = '{valid: 1'b1, ctr: CTR_STRONG_T, kind: (is_ret_e ? BP_RET : BP_JMP)};
`else
        wr_meta_d      = '{valid: 1'b1, ctr: CTR_STRONG_T, kind: BP_JMP};
`endif
      end else if (hit_e) begin
        wr_en_d         = 1'b1;
        wr_meta_d.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) meta_q[i].valid <= 1'b0;
    end else if (wr_en_d) begin
      meta_q[idx_e] <= wr_meta_d;
      tag_q[idx_e]  <= tag_e;
      if (wr_target_en_d) target_q[idx_e] <= target_e;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios, then random traffic vs a table model.
// The RAS model and RAS scenario are active when BP_RAS_EN is defined.
module tb_branch_predictor;
  localparam int WIDTH     = 32;
  localparam int ENTRIES   = 64;
  localparam int TAG_BITS  = 8;
  localparam int RAS_DEPTH = 8;
  localparam int IDX       = $clog2(ENTRIES);

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f, pred_target_f, pc_e, pc_plus4_e, target_e, pred_target_e, redirect_pc_e;
  logic        pred_taken_f, update_valid_e, branch_e, jump_e, jalr_e, taken_e;
  logic        is_call_e, is_ret_e, pred_taken_e, mispredict_e;

  int errors = 0;
  int checks = 0;

  // Reference model: one slot per index, kind 0=branch 1=jump 2=return.
  bit          mValid  [ENTRIES];
  int unsigned mTag    [ENTRIES];
  logic [31:0] mTarget [ENTRIES];
  int          mCtr    [ENTRIES];
  int          mKind   [ENTRIES];
  logic [31:0] rasQ[$];

  always #5 clk = ~clk;

  branch_predictor #(
    .WIDTH(WIDTH), .ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .pc_f(pc_f), .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
    .update_valid_e(update_valid_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .branch_e(branch_e),
    .jump_e(jump_e), .jalr_e(jalr_e), .taken_e(taken_e), .target_e(target_e),
    .is_call_e(is_call_e), .is_ret_e(is_ret_e), .pred_taken_e(pred_taken_e),
    .pred_target_e(pred_target_e), .mispredict_e(mispredict_e), .redirect_pc_e(redirect_pc_e)
  );

  function automatic int idxOf(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tagOf(input logic [31:0] pc);
    return (pc >> (IDX + 2)) % (1 << TAG_BITS);
  endfunction

  function automatic bit modelHit(input logic [31:0] pc);
    return mValid[idxOf(pc)] && (mTag[idxOf(pc)] == tagOf(pc));
  endfunction

  function automatic logic modelTaken(input logic [31:0] pc);
    if (!modelHit(pc)) return 1'b0;
    return (mKind[idxOf(pc)] != 0) || (mCtr[idxOf(pc)] >= 2);
  endfunction

  function automatic logic [31:0] modelTarget(input logic [31:0] pc);
    if (!modelHit(pc)) return 32'h0;
    if ((mKind[idxOf(pc)] == 2) && (rasQ.size() > 0)) return rasQ[$];
    return mTarget[idxOf(pc)];
  endfunction

  task automatic modelUpdate(input logic valid, input logic br, input logic jmp, input logic taken,
                             input logic call, input logic ret, input logic [31:0] pc,
                             input logic [31:0] tgt);
    int  i;
    bit  hit;
    if (!valid) return;
    i   = idxOf(pc);
    hit = modelHit(pc);
    if (br) begin
      if (hit) begin
        mCtr[i] = taken ? ((mCtr[i] == 3) ? 3 : mCtr[i] + 1) : ((mCtr[i] == 0) ? 0 : mCtr[i] - 1);
        if (taken) mTarget[i] = tgt;
      end else if (taken) begin
        mValid[i] = 1; mTag[i] = tagOf(pc); mTarget[i] = tgt; mCtr[i] = 2; mKind[i] = 0;
      end
    end else if (jmp) begin
      mValid[i] = 1; mTag[i] = tagOf(pc); mTarget[i] = tgt; mCtr[i] = 3;
`ifdef BP_RAS_EN
      mKind[i] = ret ? 2 : 1;
`else
      mKind[i] = 1;
`endif
    end else if (hit) begin
      mValid[i] = 0;
    end
`ifdef BP_RAS_EN
    if (ret && (rasQ.size() > 0)) void'(rasQ.pop_back());
    if (call) begin
      rasQ.push_back(pc + 32'd4);
      if (rasQ.size() > RAS_DEPTH) void'(rasQ.pop_front());
    end
`else
    if (call || ret) i = i;
`endif
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic driveIdle();
    update_valid_e = 0; branch_e = 0; jump_e = 0; jalr_e = 0; taken_e = 0;
    is_call_e = 0; is_ret_e = 0; pred_taken_e = 0; pc_e = 0; pc_plus4_e = 4;
    target_e = 0; pred_target_e = 0;
  endtask

  // Drives one execute-stage instruction plus a fetch lookup, checks both before the edge.
  task automatic applyStimulus(input string tag, input logic valid, input logic br, input logic jmp,
                               input logic jalr, input logic taken, input logic call, input logic ret,
                               input logic [31:0] pc, input logic [31:0] tgt, input logic predTaken,
                               input logic [31:0] predTarget, input logic [31:0] lookupPc);
    logic        expMis;
    logic [31:0] expRedirect;
    update_valid_e = valid; branch_e = br; jump_e = jmp; jalr_e = jalr; taken_e = taken;
    is_call_e = call; is_ret_e = ret; pc_e = pc; pc_plus4_e = pc + 32'd4; target_e = tgt;
    pred_taken_e = predTaken; pred_target_e = predTarget; pc_f = lookupPc;
    expMis      = valid && ((predTaken != taken) || (taken && (predTarget != tgt)));
    expRedirect = !valid ? 32'h0 : (taken ? tgt : pc + 32'd4);
    @(negedge clk);
    checkOutput({tag, ".predTaken"}, {31'b0, pred_taken_f}, {31'b0, modelTaken(lookupPc)});
    checkOutput({tag, ".predTarget"}, pred_target_f, modelTarget(lookupPc));
    checkOutput({tag, ".mispredict"}, {31'b0, mispredict_e}, {31'b0, expMis});
    checkOutput({tag, ".redirect"}, redirect_pc_e, expRedirect);
    @(posedge clk);
    modelUpdate(valid, br, jmp, taken, call, ret, pc, tgt);
    #1;
    driveIdle();
  endtask

  task automatic expectLookup(input string tag, input logic [31:0] pc, input logic expTaken,
                              input logic [31:0] expTarget, input bit checkTgt);
    pc_f = pc;
    @(negedge clk);
    checkOutput({tag, ".taken"}, {31'b0, pred_taken_f}, {31'b0, expTaken});
    if (checkTgt) checkOutput({tag, ".target"}, pred_target_f, expTarget);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pickPc();
    return (32'(($urandom % 16)) << 2) | (32'(($urandom % 4)) << 8) | (32'(($urandom % 2)) << 16);
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: observed=no finish expected=finish");
    $fatal(1, "[TB] time limit expired");
  end

  initial begin
    logic [31:0] pc, tgt, lpc, pt;
    logic        tk, jl, cl, rt, ptk;
    int          r;
    for (int i = 0; i < ENTRIES; i++) mValid[i] = 0;
    driveIdle();
    rst  = 1;
    pc_f = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.taken", {31'b0, pred_taken_f}, 32'h0);
    checkOutput("reset.target", pred_target_f, 32'h0);
    checkOutput("reset.mispredict", {31'b0, mispredict_e}, 32'h0);
    rst = 0;

    applyStimulus("br1", 1, 1, 0, 0, 1, 0, 0, 32'h100, 32'h80, modelTaken(32'h100), modelTarget(32'h100), 32'h100);
    expectLookup("afterBr1", 32'h100, 1, 32'h80, 1);
    repeat (2)
      applyStimulus("brNt", 1, 1, 0, 0, 0, 0, 0, 32'h100, 32'h80, modelTaken(32'h100), modelTarget(32'h100), 32'h100);
    expectLookup("ctr0", 32'h100, 0, 32'h0, 0);
    applyStimulus("brT", 1, 1, 0, 0, 1, 0, 0, 32'h100, 32'h80, modelTaken(32'h100), modelTarget(32'h100), 32'h100);
    expectLookup("ctr1", 32'h100, 0, 32'h0, 0);
    repeat (3)
      applyStimulus("brT", 1, 1, 0, 0, 1, 0, 0, 32'h100, 32'h80, modelTaken(32'h100), modelTarget(32'h100), 32'h100);
    expectLookup("ctr3", 32'h100, 1, 32'h80, 1);
    applyStimulus("brNt", 1, 1, 0, 0, 0, 0, 0, 32'h100, 32'h80, modelTaken(32'h100), modelTarget(32'h100), 32'h100);
    expectLookup("ctr2", 32'h100, 1, 32'h80, 1);

    applyStimulus("tgtMis", 1, 1, 0, 0, 1, 0, 0, 32'h400, 32'h84, 1, 32'h80, 32'h100);
    checkOutput("tgtMis.entry", {31'b0, modelTaken(32'h400)}, 32'h1);

    applyStimulus("jmpAlias", 1, 0, 1, 0, 1, 0, 0, 32'h10200, 32'h500, 0, 32'h0, 32'h200);
    expectLookup("aliasHit", 32'h200, 1, 32'h500, 1);
    applyStimulus("addAlias", 1, 0, 0, 0, 0, 0, 0, 32'h200, 32'h0, 1, 32'h500, 32'h200);
    expectLookup("aliasGone", 32'h200, 0, 32'h0, 1);
    expectLookup("aliasGone2", 32'h10200, 0, 32'h0, 1);

    applyStimulus("bubble", 0, 1, 0, 0, 1, 0, 0, 32'h600, 32'h40, 0, 32'h0, 32'h600);
    expectLookup("bubbleNoWrite", 32'h600, 0, 32'h0, 1);
    applyStimulus("ntMiss", 1, 1, 0, 0, 0, 0, 0, 32'h700, 32'h40, 0, 32'h0, 32'h700);
    expectLookup("ntMissNoAlloc", 32'h700, 0, 32'h0, 1);

`ifdef BP_RAS_EN
    applyStimulus("call", 1, 0, 1, 0, 1, 1, 0, 32'h10, 32'h300, modelTaken(32'h10), modelTarget(32'h10), 32'h10);
    applyStimulus("ret", 1, 0, 1, 1, 1, 0, 1, 32'h300, 32'h14, modelTaken(32'h300), modelTarget(32'h300), 32'h300);
    for (int k = 0; k < 9; k++)
      applyStimulus("call9", 1, 0, 1, 0, 1, 1, 0, 32'h1010 + 32'(8 * k), 32'h2000, 1, 32'h2000, 32'h300);
    expectLookup("rasNewest", 32'h300, 1, 32'h1054, 1);
    for (int k = 0; k < 8; k++)
      applyStimulus("retPop", 1, 0, 1, 1, 1, 0, 1, 32'h300, modelTarget(32'h300), 1, modelTarget(32'h300), 32'h300);
    expectLookup("rasEmpty", 32'h300, 1, 32'h101c, 1);
`endif

    for (int n = 0; n < 400; n++) begin
      pc  = pickPc();
      lpc = pickPc();
      tgt = $urandom & 32'h0001_fffc;
      r   = int'($urandom % 10);
      jl  = $urandom % 2 == 1;
      cl  = $urandom % 2 == 1;
      rt  = jl && !cl && ($urandom % 2 == 1);
      tk  = $urandom % 2 == 1;
      ptk = ($urandom % 4 == 0) ? ($urandom % 2 == 1) : modelTaken(pc);
      pt  = ($urandom % 4 == 0) ? ($urandom & 32'h0001_fffc) : modelTarget(pc);
      if (r < 5)      applyStimulus("rndBr", 1, 1, 0, 0, tk, 0, 0, pc, tgt, ptk, pt, lpc);
      else if (r < 7) applyStimulus("rndJmp", 1, 0, 1, jl, 1, cl, rt, pc, tgt, ptk, pt, lpc);
      else if (r < 9) applyStimulus("rndOther", 1, 0, 0, 0, 0, 0, 0, pc, tgt, ptk, pt, lpc);
      else            applyStimulus("rndBubble", 0, 1, 1, jl, tk, cl, rt, pc, tgt, ptk, pt, lpc);
    end

    update_valid_e = 1; jump_e = 1; taken_e = 1; pc_e = 32'h100; pc_plus4_e = 32'h104; target_e = 32'h900;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    driveIdle();
    for (int i = 0; i < ENTRIES; i++) mValid[i] = 0;
    rasQ.delete();
    expectLookup("midReset", 32'h100, 0, 32'h0, 1);
    for (int n = 0; n < 4; n++) begin
      lpc = pickPc();
      expectLookup("midResetRnd", lpc, modelTaken(lpc), modelTarget(lpc), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
